// File: rtl/mdu_arbiter.sv
// Two-port arbiter in front of a shared MDU: grants one op at a time, issues it for a single
// cycle, waits out multi-cycle ops and returns MFHI/MFLO results to the requester that asked.
module mdu_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter int DW          = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   input  logic [5:0]    req0_type,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   output logic          req0_ready,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_data,
   input  logic          req1_valid,
   input  logic [5:0]    req1_type,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   output logic          req1_ready,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_data,
   output logic [5:0]    mdu_type,
   output logic [DW-1:0] mdu_in1,
   output logic [DW-1:0] mdu_in2,
   output logic          mdu_start,
   input  logic [DW-1:0] mdu_out,
   input  logic          mdu_busy,
   output logic [1:0]    dbg_state
);

   // Handshake: a request transfers on a rising clk edge where reqN_valid & reqN_ready are both 1.
   // Ready depends only on valid, state, rr pointer and mdu_busy; a requester must hold its op
   // stable while valid is high and may drop valid at any time before the transfer.

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [5:0] OP_MULT  = 6'h15;
   localparam logic [5:0] OP_DIVU  = 6'h18;
   localparam logic [5:0] OP_MFHI  = 6'h19;
   localparam logic [5:0] OP_MFLO  = 6'h1A;
   localparam logic [5:0] OP_MTLO  = 6'h1C;

   logic [1:0]    state_q;
   logic          rr_q;
   logic          id_q;
   logic [5:0]    type_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] rsp_q;

   logic grant0, grant1, can_accept, accept;
   logic in_issue, op_legal, op_muldiv, op_mf;

   // rr_q = 1 means requester 1 wins a tie.
   assign grant1     = req1_valid & (~req0_valid | (ROUND_ROBIN & rr_q));
   assign grant0     = req0_valid & ~grant1;
   assign can_accept = (state_q == ST_IDLE) & ~mdu_busy;
   assign req0_ready = can_accept & grant0;
   assign req1_ready = can_accept & grant1;
   assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   assign in_issue  = (state_q == ST_ISSUE);
   assign op_legal  = (type_q >= OP_MULT) && (type_q <= OP_MTLO);
   assign op_muldiv = (type_q >= OP_MULT) && (type_q <= OP_DIVU);
   assign op_mf     = (type_q == OP_MFHI) || (type_q == OP_MFLO);

   // The MDU acts on mdu_type every cycle, so it must be zero outside the issue cycle.
   assign mdu_type  = (in_issue && op_legal) ? type_q : 6'h00;
   assign mdu_in1   = in_issue ? a_q : '0;
   assign mdu_in2   = in_issue ? b_q : '0;
   assign mdu_start = in_issue & op_muldiv;

   assign rsp0_valid = (state_q == ST_RESP) & ~id_q;
   assign rsp1_valid = (state_q == ST_RESP) &  id_q;
   assign rsp0_data  = rsp0_valid ? rsp_q : '0;
   assign rsp1_data  = rsp1_valid ? rsp_q : '0;
   assign dbg_state  = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         rr_q    <= 1'b0;
         id_q    <= 1'b0;
         type_q  <= 6'h00;
         a_q     <= '0;
         b_q     <= '0;
         rsp_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  id_q    <= grant1;
                  type_q  <= grant1 ? req1_type : req0_type;
                  a_q     <= grant1 ? req1_a : req0_a;
                  b_q     <= grant1 ? req1_b : req0_b;
                  rr_q    <= grant0;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (op_muldiv) begin
                  state_q <= ST_WAIT;
               end else if (op_mf) begin
                  rsp_q   <= mdu_out;
                  state_q <= ST_RESP;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!mdu_busy) state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
